// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster geometry, derived totals and sync windows
package vga_timing_pkg;
  localparam int POS_W = 10;
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_BOTTOM = 10;
  localparam int V_SYNC = 2;
  localparam int V_TOP = 33;
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
  localparam int V_SYNC_END = V_SYNC_START + V_SYNC - 1;
endpackage

// File: rtl/vga_sync_axis.sv
// vga_sync_axis: wrap counter 0..TOTAL-1 advancing on en (clk, rst_n, en -> count, sync_n); sync_n is a registered active-low decode of [SYNC_START,SYNC_END] sampled every clock
module vga_sync_axis
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = 800,
  parameter int SYNC_START = 656,
  parameter int SYNC_END = 751,
  parameter int W = POS_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         sync_n
);
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  localparam logic [W-1:0] SS = W'(SYNC_START);
  localparam logic [W-1:0] SE = W'(SYNC_END);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      sync_n <= 1'b1;
    end else begin
      if (en) count <= (count == LAST) ? '0 : count + 1'b1;
      sync_n <= !(count >= SS && count <= SE);
    end
endmodule

// File: rtl/vga_hvsync_generator.sv
// vga_hvsync_generator: free-running VGA raster timing (clk, rst_n -> hsync, vsync, display_on, hpos, vpos)
module vga_hvsync_generator #(
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BACK = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_BOTTOM = vga_timing_pkg::V_BOTTOM,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_TOP = vga_timing_pkg::V_TOP
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
  logic h_wrap;
  assign h_wrap = hpos == 10'(H_TOTAL - 1);
  vga_sync_axis #(
    .TOTAL(H_TOTAL),
    .SYNC_START(H_DISPLAY + H_FRONT),
    .SYNC_END(H_DISPLAY + H_FRONT + H_SYNC - 1),
    .W(10)
  ) u_h (
    .clk(clk),
    .rst_n(rst_n),
    .en(1'b1),
    .count(hpos),
    .sync_n(hsync)
  );
  vga_sync_axis #(
    .TOTAL(V_TOTAL),
    .SYNC_START(V_DISPLAY + V_BOTTOM),
    .SYNC_END(V_DISPLAY + V_BOTTOM + V_SYNC - 1),
    .W(10)
  ) u_v (
    .clk(clk),
    .rst_n(rst_n),
    .en(h_wrap),
    .count(vpos),
    .sync_n(vsync)
  );
  assign display_on = (hpos < 10'(H_DISPLAY)) && (vpos < 10'(V_DISPLAY));
endmodule

// File: tb/tb_vga_hvsync_generator.sv
// tb_vga_hvsync_generator: directed checks of full-size line timing and reduced-geometry frame timing
module tb_vga_hvsync_generator;
  logic clk = 1'b0;
  logic rst_n, rst_s_n;
  logic hsync, vsync, display_on, hsync_s, vsync_s, display_on_s;
  logic [9:0] hpos, vpos, hpos_s, vpos_s;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  vga_hvsync_generator dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
    .display_on(display_on), .hpos(hpos), .vpos(vpos)
  );
  // small raster: H 8+2+3+2=15 (sync 10..12), V 6+2+2+3=13 (sync 8..9), frame 195 clocks
  vga_hvsync_generator #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(3)
  ) dut_s (
    .clk(clk), .rst_n(rst_s_n), .hsync(hsync_s), .vsync(vsync_s),
    .display_on(display_on_s), .hpos(hpos_s), .vpos(vpos_s)
  );
  typedef struct {
    int t;
    int h;
    int v;
    int hs;
    int vs;
    int de;
  } vec_t;
  vec_t vecs[12];
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int t, n, first_h, first_v, last_h, de_n, rises, first_rise, last_rise, first_t;
    bit found, prev;
    vecs[0] = '{1, 1, 0, 1, 1, 1};
    vecs[1] = '{639, 639, 0, 1, 1, 1};
    vecs[2] = '{640, 640, 0, 1, 1, 0};
    vecs[3] = '{656, 656, 0, 1, 1, 0};
    vecs[4] = '{657, 657, 0, 0, 1, 0};
    vecs[5] = '{752, 752, 0, 0, 1, 0};
    vecs[6] = '{753, 753, 0, 1, 1, 0};
    vecs[7] = '{799, 799, 0, 1, 1, 0};
    vecs[8] = '{800, 0, 1, 1, 1, 1};
    vecs[9] = '{1457, 657, 1, 0, 1, 0};
    vecs[10] = '{1600, 0, 2, 1, 1, 1};
    vecs[11] = '{4000, 0, 5, 1, 1, 1};
    rst_n = 1'b0;
    rst_s_n = 1'b0;
    repeat (5) step();
    chk("rst_hpos", int'(hpos), 0);
    chk("rst_vpos", int'(vpos), 0);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_display_on", int'(display_on), 1);
    rst_n = 1'b1;
    t = 0;
    for (int i = 0; i < 12; i++) begin
      while (t < vecs[i].t) begin
        step();
        t++;
      end
      chk($sformatf("vec%0d_hpos", i), int'(hpos), vecs[i].h);
      chk($sformatf("vec%0d_vpos", i), int'(vpos), vecs[i].v);
      chk($sformatf("vec%0d_hsync", i), int'(hsync), vecs[i].hs);
      chk($sformatf("vec%0d_vsync", i), int'(vsync), vecs[i].vs);
      chk($sformatf("vec%0d_display_on", i), int'(display_on), vecs[i].de);
    end
    // hsync window on line 0 of a fresh frame
    rst_n = 1'b0;
    #1;
    chk("async_rst_hpos", int'(hpos), 0);
    step();
    rst_n = 1'b1;
    n = 0; first_h = -1; last_h = -1; de_n = 0;
    for (int k = 1; k <= 800; k++) begin
      step();
      if (!hsync) begin
        if (first_h < 0) first_h = int'(hpos);
        last_h = int'(hpos);
        n++;
      end
      if (!display_on) de_n++;
    end
    chk("hsync_low_count", n, 96);
    chk("hsync_first_hpos", first_h, 657);
    chk("hsync_last_hpos", last_h, 752);
    chk("line0_display_off_count", de_n, 160);
    chk("line_end_hpos", int'(hpos), 0);
    chk("line_end_vpos", int'(vpos), 1);
    // reduced-geometry frame: wrap, vsync window, display area
    rst_s_n = 1'b0;
    step();
    rst_s_n = 1'b1;
    n = 0; first_h = -1; first_v = -1; de_n = 0;
    for (int k = 1; k <= 195; k++) begin
      step();
      if (!vsync_s) begin
        if (first_h < 0) begin
          first_h = int'(hpos_s);
          first_v = int'(vpos_s);
        end
        n++;
      end
      if (display_on_s) de_n++;
    end
    chk("frame_wrap_hpos", int'(hpos_s), 0);
    chk("frame_wrap_vpos", int'(vpos_s), 0);
    chk("vsync_low_count", n, 30);
    chk("vsync_first_hpos", first_h, 1);
    chk("vsync_first_vpos", first_v, 8);
    chk("frame_display_on_count", de_n, 48);
    // frame tick: vsync rising edges over three frames
    rises = 0; first_rise = -1; last_rise = -1;
    prev = vsync_s;
    for (int k = 196; k <= 780; k++) begin
      step();
      if (!prev && vsync_s) begin
        rises++;
        if (first_rise < 0) first_rise = k;
        last_rise = k;
      end
      prev = vsync_s;
    end
    chk("vsync_rise_count", rises, 3);
    chk("vsync_first_rise_t", first_rise, 346);
    chk("vsync_rise_span", last_rise - first_rise, 390);
    // asynchronous reset in the middle of the vsync pulse
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      step();
      found = hpos_s == 10'd12 && vpos_s == 10'd9;
    end
    chk("midframe_point_reached", int'(found), 1);
    chk("midframe_vsync_before", int'(vsync_s), 0);
    #2;
    rst_s_n = 1'b0;
    #1;
    chk("midrst_hpos", int'(hpos_s), 0);
    chk("midrst_vpos", int'(vpos_s), 0);
    chk("midrst_hsync", int'(hsync_s), 1);
    chk("midrst_vsync", int'(vsync_s), 1);
    step();
    rst_s_n = 1'b1;
    n = 0; first_t = -1;
    for (int k = 1; k <= 195; k++) begin
      step();
      if (k == 1) chk("post_rst_hpos", int'(hpos_s), 1);
      if (!vsync_s) begin
        if (first_t < 0) first_t = k;
        n++;
      end
    end
    chk("post_rst_vsync_first_t", first_t, 121);
    chk("post_rst_vsync_low_count", n, 30);
    chk("post_rst_wrap_hpos", int'(hpos_s), 0);
    chk("post_rst_wrap_vpos", int'(vpos_s), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
